uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLIENTS, default 4: number of requesting clients, 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: byte width forwarded to the uart_tx transmitter.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum bytes per grant, 1..255.
REQ-004 SHALL have port inp_clock, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port inp_reset, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port inp_req, input, CLIENTS: per-client byte-valid request.
REQ-007 SHALL have port inp_data, input, CLIENTS*DATA_W: client k's byte in bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port inp_last, input, CLIENTS: marks the current byte as the packet end.
REQ-009 SHALL have port out_ack, output, CLIENTS: one-cycle pulse, client byte accepted.
REQ-010 SHALL have port out_valid, output, 1: byte valid toward the transmitter.
REQ-011 SHALL have port out_data, output, DATA_W: byte toward the transmitter.
REQ-012 SHALL have port inp_ready, input, 1: the transmitter can take a byte this cycle.
REQ-013 SHALL have port out_grant, output, CLIENTS: one-hot current owner; all zero when idle.
REQ-014 SHALL have port out_busy, output, 1: a grant is held.

Function
REQ-015 SHALL implement an FSM with states IDLE and GRANT.
REQ-016 In IDLE with any inp_req set, the arbiter SHALL register a round-robin winner and enter GRANT on the next edge.
- Search starts at last_owner+1 and wraps modulo CLIENTS.
REQ-017 In GRANT:
- out_valid = inp_req[g].
- out_data = the inp_data slice of client g.
- Both are combinational from the registered grant g.
REQ-018 A transfer occurs when out_valid && inp_ready; out_ack[g] SHALL pulse high in that same cycle and is combinational from inp_ready.
REQ-019 out_ack bits other than g SHALL be 0 in every cycle; no transfer or ack SHALL occur in IDLE.
REQ-020 The request-to-first-out_valid latency SHALL be exactly 1 cycle when idle.
REQ-021 Each transfer SHALL increment an 8-bit burst counter; the counter is cleared on entry to GRANT.
REQ-022 GRANT SHALL return to IDLE on the edge after a transfer with inp_last[g]=1.
REQ-023 GRANT SHALL return to IDLE on the edge after the transfer that reaches MAX_BURST bytes, whether or not inp_last is set.
REQ-024 GRANT SHALL return to IDLE if inp_req[g] is 0 for a cycle (client abandon); no ack is issued in that cycle.
REQ-025 On every return to IDLE, last_owner SHALL be set to g.
REQ-026 IDLE SHALL always last at least one cycle between grants, giving a fixed 1-cycle bubble.
REQ-027 Requests arriving from other clients during GRANT SHALL be held pending and evaluated in the next IDLE.
REQ-028 The design SHALL not change out_data while out_valid=1 and inp_ready=0; clients SHALL hold data until acked.
REQ-029 inp_last with inp_req=0 SHALL be ignored.
REQ-030 out_busy SHALL equal (state==GRANT), and out_grant SHALL be one-hot exactly when out_busy=1.

Reset
REQ-031 While inp_reset=0, the following SHALL hold asynchronously:
- state=IDLE, burst counter=0, last_owner=CLIENTS-1 (client 0 first).
- out_valid=0, out_ack=0, out_grant=0, out_busy=0, out_data=0.
REQ-032 Reset asserted mid-burst SHALL drop the grant immediately with no further ack; the partial packet is abandoned.
REQ-033 After deassertion, the first grant SHALL be decided on the first rising edge with inp_reset=1.

Structure
REQ-034 A shared package uart_arb_pkg SHALL hold:
- the state enum (ARB_IDLE, ARB_GRANT);
- default constants ARB_CLIENTS=4, ARB_DATA_W=8, ARB_MAX_BURST=16.
REQ-035 The round-robin search SHALL be a sub-module rr_picker.
- Inputs: req vector and last_owner.
- Outputs: one-hot winner and its index.
- Purely combinational.

Verification
REQ-036 Scenario: client 2 sends 3 bytes (0x41, 0x42, 0x43 with last), inp_ready=1 -> out_data 0x41/0x42/0x43 on consecutive cycles, out_ack[2] pulses 3 times, IDLE follows.
REQ-037 Scenario: clients 0, 1 and 3 request together from reset, single-byte packets -> grant order 0, 1, 3, 0, and each grant separated by 1 idle cycle.
REQ-038 Scenario: client 1 streams 20 bytes with no last, MAX_BURST=16, client 0 also requesting -> exactly 16 acks to client 1, then client 0 granted.
REQ-039 Scenario: inp_ready held 0 for 5 cycles mid-burst -> out_valid stays 1, out_data stable, no ack, then transfer resumes.
REQ-040 Scenario: inp_reset pulled low during byte 2 of 4 -> out_valid, out_grant and out_ack go 0 without a clock edge; after release, client 0 has priority.
REQ-041 Scenario: owner drops inp_req after 1 byte -> return to IDLE one cycle later; the next pending client is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding, default sizing and the index-width helper.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_CLIENTS   = 4;
  localparam int ARB_DATA_W    = 8;
  localparam int ARB_MAX_BURST = 16;
  localparam int ARB_BURST_W   = 8;

  // Width of a client index; never below one bit so a 2-client build stays legal.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search starting just after i_last_owner, wrapping modulo N.
// Purely combinational: zero latency, no flow control of its own.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N     = ARB_CLIENTS,
  parameter int IDX_W = arb_idx_w(ARB_CLIENTS)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [N-1:0]     o_winner,
  output logic [IDX_W-1:0] o_winner_idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // One extra bit on the sum holds last_owner + N before the wrap subtraction.
  always_comb begin
    o_winner     = '0;
    o_winner_idx = '0;
    w_found      = 1'b0;
    w_sum        = '0;
    w_cand       = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum = {1'b0, i_last_owner} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_winner[w_cand] = 1'b1;
        o_winner_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx from CLIENTS byte streams, bursts capped at MAX_BURST.
// First byte valid 1 cycle after an idle request; inp_ready low stalls with data held, ack only on transfer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLIENTS   = ARB_CLIENTS,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                      inp_clock,
  input  logic                      inp_reset,
  input  logic [CLIENTS-1:0]        inp_req,
  input  logic [CLIENTS*DATA_W-1:0] inp_data,
  input  logic [CLIENTS-1:0]        inp_last,
  output logic [CLIENTS-1:0]        out_ack,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      inp_ready,
  output logic [CLIENTS-1:0]        out_grant,
  output logic                      out_busy
);

  localparam int IDX_W = arb_idx_w(CLIENTS);
  localparam logic [ARB_BURST_W-1:0] LP_BURST_LAST = ARB_BURST_W'(MAX_BURST - 1);

  arb_state_t               r_state;
  arb_state_t               w_next_state;
  logic [CLIENTS-1:0]       r_grant;
  logic [IDX_W-1:0]         r_grant_idx;
  logic [IDX_W-1:0]         r_last_owner;
  logic [ARB_BURST_W-1:0]   r_burst_cnt;

  logic [CLIENTS-1:0]       w_pick_onehot;
  logic [IDX_W-1:0]         w_pick_idx;
  logic                     w_any_req;
  logic                     w_own_req;
  logic                     w_own_last;
  logic                     w_xfer;
  logic                     w_burst_done;
  logic [DATA_W-1:0]        w_data_arr [CLIENTS];

  for (genvar k = 0; k < CLIENTS; k++) begin : g_unpack
    assign w_data_arr[k] = inp_data[k*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N     (CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req        (inp_req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick_onehot),
    .o_winner_idx (w_pick_idx)
  );

  assign w_any_req    = |inp_req;
  assign w_own_req    = inp_req[r_grant_idx];
  assign w_own_last   = inp_last[r_grant_idx];
  assign w_xfer       = (r_state == ARB_GRANT) && w_own_req && inp_ready;
  assign w_burst_done = (r_burst_cnt == LP_BURST_LAST);

  always_ff @(posedge inp_clock or negedge inp_reset) begin
    if (!inp_reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // An owner that drops its request releases the grant without an ack that cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_next_state = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!w_own_req) begin
          w_next_state = ARB_IDLE;
        end else if (w_xfer && (w_own_last || w_burst_done)) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    out_busy  = 1'b0;
    out_grant = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ack   = '0;
    if (r_state == ARB_GRANT) begin
      out_busy  = 1'b1;
      out_grant = r_grant;
      out_valid = w_own_req;
      out_data  = w_data_arr[r_grant_idx];
      if (w_xfer) begin
        out_ack[r_grant_idx] = 1'b1;
      end
    end
  end

  // Grant bookkeeping: winner latched on the IDLE edge, owner recorded on every release.
  always_ff @(posedge inp_clock or negedge inp_reset) begin
    if (!inp_reset) begin
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_last_owner <= IDX_W'(CLIENTS - 1);
      r_burst_cnt  <= '0;
    end else if (r_state == ARB_IDLE) begin
      if (w_any_req) begin
        r_grant     <= w_pick_onehot;
        r_grant_idx <= w_pick_idx;
        r_burst_cnt <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (w_next_state == ARB_IDLE) begin
        r_last_owner <= r_grant_idx;
        r_grant      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change on the falling edge, outputs checked 1 ns later.
// Covers reset, single/multi-client arbitration, burst cap, stall, async reset and abandon.
module tb_uart_tx_arbiter;

  localparam int CLIENTS   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;

  logic                      inp_clock = 1'b0;
  logic                      inp_reset;
  logic [CLIENTS-1:0]        inp_req;
  logic [CLIENTS*DATA_W-1:0] inp_data;
  logic [CLIENTS-1:0]        inp_last;
  logic                      inp_ready;
  logic [CLIENTS-1:0]        out_ack;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [CLIENTS-1:0]        out_grant;
  logic                      out_busy;

  int total = 0;
  int bad   = 0;
  int acks;
  int order [4] = '{0, 1, 3, 0};

  always #5 inp_clock = ~inp_clock;

  uart_tx_arbiter #(
    .CLIENTS   (CLIENTS),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .inp_clock (inp_clock),
    .inp_reset (inp_reset),
    .inp_req   (inp_req),
    .inp_data  (inp_data),
    .inp_last  (inp_last),
    .out_ack   (out_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .inp_ready (inp_ready),
    .out_grant (out_grant),
    .out_busy  (out_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_out(input string tag, input logic busy, input logic [3:0] grant,
                         input logic valid, input logic [7:0] data, input logic [3:0] ack);
    #1;
    chk({tag, ".busy"},  32'(out_busy),  32'(busy));
    chk({tag, ".grant"}, 32'(out_grant), 32'(grant));
    chk({tag, ".valid"}, 32'(out_valid), 32'(valid));
    chk({tag, ".data"},  32'(out_data),  32'(data));
    chk({tag, ".ack"},   32'(out_ack),   32'(ack));
  endtask

  task automatic put(input int k, input logic [7:0] v);
    inp_data[k*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    inp_reset = 1'b0;
    inp_req   = '0;
    inp_data  = '0;
    inp_last  = '0;
    inp_ready = 1'b1;

    // Reset state, including with a request pending during reset
    repeat (2) @(negedge inp_clock);
    exp_out("rst", 0, 4'b0000, 0, 8'h00, 4'b0000);
    inp_req = 4'b0100;
    @(negedge inp_clock);
    exp_out("rst_req", 0, 4'b0000, 0, 8'h00, 4'b0000);
    inp_req   = '0;
    inp_reset = 1'b1;

    // Client 2 sends 0x41 0x42 0x43(last)
    @(negedge inp_clock);
    inp_req = 4'b0100; put(2, 8'h41);
    exp_out("s1_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    exp_out("s1_b0", 1, 4'b0100, 1, 8'h41, 4'b0100);
    @(negedge inp_clock);
    put(2, 8'h42);
    exp_out("s1_b1", 1, 4'b0100, 1, 8'h42, 4'b0100);
    @(negedge inp_clock);
    put(2, 8'h43); inp_last = 4'b0100;
    exp_out("s1_b2", 1, 4'b0100, 1, 8'h43, 4'b0100);
    @(negedge inp_clock);
    inp_req = '0; inp_last = '0;
    exp_out("s1_end", 0, 4'b0000, 0, 8'h00, 4'b0000);

    // Reset again so arbitration starts from client 0
    @(negedge inp_clock);
    inp_reset = 1'b0;
    exp_out("s2_rst", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    inp_reset = 1'b1;

    // Clients 0,1,3 with single-byte packets: order 0,1,3,0, one idle cycle between
    @(negedge inp_clock);
    inp_req = 4'b1011; inp_last = 4'b1111;
    for (int k = 0; k < 4; k++) put(k, 8'(8'h10 + k));
    exp_out("s2_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge inp_clock);
      exp_out($sformatf("s2_g%0d", i), 1, 4'(1 << order[i]), 1, 8'(8'h10 + order[i]),
              4'(1 << order[i]));
      @(negedge inp_clock);
      if (i == 3) begin
        inp_req = '0; inp_last = '0;
      end
      exp_out($sformatf("s2_bub%0d", i), 0, 4'b0000, 0, 8'h00, 4'b0000);
    end

    // Client 1 streams without last while client 0 waits: capped at 16 bytes
    @(negedge inp_clock);
    inp_req = 4'b0011; put(0, 8'h55); put(1, 8'h80);
    exp_out("s3_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge inp_clock);
      put(1, 8'(8'h80 + i));
      exp_out($sformatf("s3_b%0d", i), 1, 4'b0010, 1, 8'(8'h80 + i), 4'b0010);
      if (out_ack[1]) acks++;
    end
    @(negedge inp_clock);
    put(1, 8'h90);
    exp_out("s3_cap", 0, 4'b0000, 0, 8'h00, 4'b0000);
    chk("s3_acks", 32'(acks), 32'd16);
    @(negedge inp_clock);
    inp_req = 4'b0001; inp_last = 4'b0001;
    exp_out("s3_c0", 1, 4'b0001, 1, 8'h55, 4'b0001);
    @(negedge inp_clock);
    inp_req = '0; inp_last = '0;
    exp_out("s3_end", 0, 4'b0000, 0, 8'h00, 4'b0000);

    // Client 3, inp_ready low for 5 cycles on byte 1
    @(negedge inp_clock);
    inp_req = 4'b1000; put(3, 8'hA0);
    exp_out("s4_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    exp_out("s4_b0", 1, 4'b1000, 1, 8'hA0, 4'b1000);
    @(negedge inp_clock);
    put(3, 8'hA1); inp_ready = 1'b0;
    exp_out("s4_stall0", 1, 4'b1000, 1, 8'hA1, 4'b0000);
    for (int i = 1; i < 5; i++) begin
      @(negedge inp_clock);
      exp_out($sformatf("s4_stall%0d", i), 1, 4'b1000, 1, 8'hA1, 4'b0000);
    end
    @(negedge inp_clock);
    inp_ready = 1'b1;
    exp_out("s4_b1", 1, 4'b1000, 1, 8'hA1, 4'b1000);
    @(negedge inp_clock);
    put(3, 8'hA2);
    exp_out("s4_b2", 1, 4'b1000, 1, 8'hA2, 4'b1000);
    @(negedge inp_clock);
    put(3, 8'hA3); inp_last = 4'b1000;
    exp_out("s4_b3", 1, 4'b1000, 1, 8'hA3, 4'b1000);
    @(negedge inp_clock);
    inp_req = '0; inp_last = '0;
    exp_out("s4_end", 0, 4'b0000, 0, 8'h00, 4'b0000);

    // Async reset during byte 2 of 4 from client 2, then client 0 wins
    @(negedge inp_clock);
    inp_req = 4'b0100; put(2, 8'hC0);
    exp_out("s5_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    exp_out("s5_b0", 1, 4'b0100, 1, 8'hC0, 4'b0100);
    @(negedge inp_clock);
    put(2, 8'hC1);
    exp_out("s5_b1", 1, 4'b0100, 1, 8'hC1, 4'b0100);
    #1 inp_reset = 1'b0;
    exp_out("s5_async", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    inp_req = 4'b0101; put(0, 8'h5A); inp_last = 4'b0001;
    exp_out("s5_hold", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    inp_reset = 1'b1;
    exp_out("s5_rel", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    exp_out("s5_c0", 1, 4'b0001, 1, 8'h5A, 4'b0001);
    @(negedge inp_clock);
    inp_req = '0; inp_last = '0;
    exp_out("s5_end", 0, 4'b0000, 0, 8'h00, 4'b0000);

    // Client 1 abandons after one byte, pending client 2 follows
    @(negedge inp_clock);
    inp_req = 4'b0110; put(1, 8'hD0); put(2, 8'hE0);
    exp_out("s6_idle", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    exp_out("s6_b0", 1, 4'b0010, 1, 8'hD0, 4'b0010);
    @(negedge inp_clock);
    inp_req = 4'b0100;
    exp_out("s6_drop", 1, 4'b0010, 0, 8'hD0, 4'b0000);
    @(negedge inp_clock);
    exp_out("s6_bub", 0, 4'b0000, 0, 8'h00, 4'b0000);
    @(negedge inp_clock);
    inp_last = 4'b0100;
    exp_out("s6_c2", 1, 4'b0100, 1, 8'hE0, 4'b0100);
    @(negedge inp_clock);
    inp_req = '0; inp_last = '0;
    exp_out("s6_end", 0, 4'b0000, 0, 8'h00, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
